// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg -- shared definitions for the sequential execute-stage ALU.
//   * 4-bit opcode encodings (OP_PASSB .. OP_MFLO)
//   * bit positions inside the 4-bit flag vector {C, Z, N, V}
//   * control FSM state type
// Optional feature macro used by the design: SEQ_ALU_DIV_EN (divider path).
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] OP_PASSB  = 4'b0000;
  localparam logic [3:0] OP_ADDSUB = 4'b0001;
  localparam logic [3:0] OP_MUL    = 4'b0010;
  localparam logic [3:0] OP_DIV    = 4'b0011;
  localparam logic [3:0] OP_AND    = 4'b0100;
  localparam logic [3:0] OP_OR     = 4'b0101;
  localparam logic [3:0] OP_NOR    = 4'b0110;
  localparam logic [3:0] OP_SRL    = 4'b0111;
  localparam logic [3:0] OP_SLL    = 4'b1000;
  localparam logic [3:0] OP_SRA    = 4'b1001;
  localparam logic [3:0] OP_LUI    = 4'b1010;
  localparam logic [3:0] OP_MFHI   = 4'b1011;
  localparam logic [3:0] OP_MFLO   = 4'b1100;

  localparam int FLAG_V = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 3;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} aluState_e;

endpackage

// File: rtl/muldiv_iter.sv
// ---------------------------------------------------------------------------
// muldiv_iter -- iterative shared multiply / restoring-divide unit.
// Operands are reduced to magnitudes on load; one product or quotient bit is
// produced per iteration (the first one on the load edge itself), and the
// signs are re-applied combinationally on the hi/lo outputs.
// Macro SEQ_ALU_DIV_EN compiles in the divide path (and the isDiv port).
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   load            capture a/b and perform iteration 1
//   run             perform one further iteration
//   isDiv           divide (1) or multiply (0); only with SEQ_ALU_DIV_EN
//   isSigned        treat a/b as two's complement
//   a, b            operands (a = multiplicand/dividend, b = multiplier/divisor)
//   hi, lo          sign-corrected result (product, or remainder/quotient)
//   last            the iteration performed on this edge is the final one
// ---------------------------------------------------------------------------
module muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             run,
`ifdef SEQ_ALU_DIV_EN
  input  logic             isDiv,
`endif
  input  logic             isSigned,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             last
);

  logic [WIDTH-1:0]   accHi, accLo, operand;
  logic [WIDTH-1:0]   magA, magB, curHi, curLo, curOp, nextHi, nextLo;
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] negProd;
  logic [SHW-1:0]     cnt;
  logic               negLo, negHi, curDiv;
`ifdef SEQ_ALU_DIV_EN
  logic               modeDiv;
  logic [WIDTH:0]     remShift, remDiff;
`endif

  assign magA = (isSigned && a[WIDTH-1]) ? -a : a;
  assign magB = (isSigned && b[WIDTH-1]) ? -b : b;

  // On the load edge the iteration works on the fresh magnitudes rather than
  // the accumulators, so WIDTH iterations fit between load and FIX.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    curDiv = 1'b0;
`ifdef SEQ_ALU_DIV_EN
    curDiv = load ? isDiv : modeDiv;
`endif
    curHi  = load ? '0 : accHi;
    curLo  = load ? (curDiv ? magA : magB) : accLo;
    curOp  = load ? (curDiv ? magB : magA) : operand;

    // Shift-add: conditionally add multiplicand to the upper half, then
    // shift {carry, hi, lo} right by one.
    mulSum = {1'b0, curHi} + (curLo[0] ? {1'b0, curOp} : '0);
    nextHi = mulSum[WIDTH:1];
    nextLo = {mulSum[0], curLo[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
    // Restoring divide: partial remainder is WIDTH+1 bits after the shift;
    // bit WIDTH of the difference is the borrow.
    remShift = {curHi, curLo[WIDTH-1]};
    remDiff  = remShift - {1'b0, curOp};
    if (curDiv) begin
      if (!remDiff[WIDTH]) begin
        nextHi = remDiff[WIDTH-1:0];
        nextLo = {curLo[WIDTH-2:0], 1'b1};
      end else begin
        nextHi = remShift[WIDTH-1:0];
        nextLo = {curLo[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      accHi   <= '0;
      accLo   <= '0;
      operand <= '0;
      cnt     <= '0;
      negLo   <= 1'b0;
      negHi   <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      modeDiv <= 1'b0;
`endif
    end else if (load) begin
      accHi   <= nextHi;
      accLo   <= nextLo;
      operand <= curOp;
      cnt     <= SHW'(1);
      negLo   <= isSigned && (a[WIDTH-1] ^ b[WIDTH-1]);
      negHi   <= isSigned && (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef SEQ_ALU_DIV_EN
      modeDiv <= isDiv;
      // Remainder follows the dividend's sign, not the quotient's.
      if (isDiv) negHi <= isSigned && a[WIDTH-1];
`endif
    end else if (run) begin
      accHi <= nextHi;
      accLo <= nextLo;
      cnt   <= cnt + SHW'(1);
    end
  end

  assign last    = run && (cnt == SHW'(WIDTH - 1));
  assign negProd = -{accHi, accLo};

  always_comb begin
    hi = negLo ? negProd[2*WIDTH-1:WIDTH] : accHi;
    lo = negLo ? negProd[WIDTH-1:0]       : accLo;
`ifdef SEQ_ALU_DIV_EN
    if (modeDiv) begin
      hi = negHi ? -accHi : accHi;
      lo = negLo ? -accLo : accLo;
    end
`endif
  end

endmodule

// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu -- clocked execute-stage ALU with an iterative multiply/divide unit,
// architectural HI/LO registers and a start/busy/done handshake.
// Macro SEQ_ALU_DIV_EN compiles in division; without it opcode 0011 is
// treated as illegal.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               issue; honoured only while busy=0
//   operation[3:0]      opcode (alu_pkg OP_*)
//   sign[1:0]           bit0 signed, bit1 subtract (add/sub only)
//   A, B                operands, captured on an accepted start
//   Y                   registered result
//   outHI, outLO        HI/LO registers
//   carryFlag[3:0]      {C, Z, N, V}
//   busy                multiply/divide in progress
//   done                one-cycle completion pulse
//   err                 one-cycle pulse with done on illegal op / divide by 0
// ---------------------------------------------------------------------------
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       operation,
  input  logic [1:0]       sign,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] outHI,
  output logic [WIDTH-1:0] outLO,
  output logic [3:0]       carryFlag,
  output logic             busy,
  output logic             done,
  output logic             err
);

  aluState_e        state;
  logic [WIDTH-1:0] resY, addB, iterHi, iterLo;
  logic [WIDTH:0]   addSum;
  logic [3:0]       resFlags;
  logic             writesY, addV, goMul, goDiv, divZero, iterLoad, iterRun, iterLast;

  always_comb begin
    addB   = sign[1] ? ~B : B;
    addSum = {1'b0, A} + {1'b0, addB} + {{WIDTH{1'b0}}, sign[1]};
    addV   = sign[0] && (A[WIDTH-1] == addB[WIDTH-1]) && (addSum[WIDTH-1] != A[WIDTH-1]);

    resY    = '0;
    writesY = 1'b1;
    case (operation)
      OP_PASSB:  resY = B;
      OP_ADDSUB: resY = addSum[WIDTH-1:0];
      OP_AND:    resY = A & B;
      OP_OR:     resY = A | B;
      OP_NOR:    resY = ~(A | B);
      OP_SRL:    resY = B >> A[SHW-1:0];
      OP_SLL:    resY = B << A[SHW-1:0];
      OP_SRA:    resY = WIDTH'($signed(B) >>> A[SHW-1:0]);
      OP_LUI:    resY = {A[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_MFHI:   resY = outHI;
      OP_MFLO:   resY = outLO;
      default:   writesY = 1'b0;  // mult, div and illegal opcodes
    endcase

    resFlags         = '0;
    resFlags[FLAG_N] = resY[WIDTH-1];
    resFlags[FLAG_Z] = (resY == '0);
    if (operation == OP_ADDSUB) begin
      resFlags[FLAG_C] = addSum[WIDTH];
      resFlags[FLAG_V] = addV;
    end

    goMul   = (operation == OP_MUL);
    goDiv   = 1'b0;
    divZero = 1'b0;
`ifdef SEQ_ALU_DIV_EN
    goDiv   = (operation == OP_DIV) && (B != '0);
    divZero = (operation == OP_DIV) && (B == '0);
`endif
  end

  assign iterLoad = (state == IDLE) && start && (goMul || goDiv);
  assign iterRun  = (state == MUL) || (state == DIV);

  muldiv_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_iter (
    .clk      (clk),
    .reset    (reset),
    .load     (iterLoad),
    .run      (iterRun),
`ifdef SEQ_ALU_DIV_EN
    .isDiv    (goDiv),
`endif
    .isSigned (sign[0]),
    .a        (A),
    .b        (B),
    .hi       (iterHi),
    .lo       (iterLo),
    .last     (iterLast)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      Y         <= '0;
      outHI     <= '0;
      outLO     <= '0;
      carryFlag <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (goMul) begin
            state <= MUL;
            busy  <= 1'b1;
          end else if (goDiv) begin
            state <= DIV;
            busy  <= 1'b1;
          end else if (divZero) begin
            outHI <= A;
            outLO <= '1;
            done  <= 1'b1;
            err   <= 1'b1;
          end else if (!writesY) begin
            done <= 1'b1;
            err  <= 1'b1;
          end else begin
            Y         <= resY;
            carryFlag <= resFlags;
            done      <= 1'b1;
          end
        end
        MUL, DIV: if (iterLast) state <= FIX;
        FIX: begin
          outHI <= iterHi;
          outLO <= iterLo;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
